// File: rtl/alu_issue_ctrl.sv
// Issue front end for a combinational ALU: decodes aluop/funct into a selector, holds operands for the
// required settle time, then captures and returns the ALU result over a valid/ready handshake.
module alu_issue_ctrl #(
    parameter int MUL_CYCLES = 2,
    parameter int DIV_CYCLES = 4
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [1:0]  aluop,
    input  logic [5:0]  funct,
    input  logic [31:0] a,
    input  logic [31:0] b,
    output logic [31:0] alu_op1,
    output logic [31:0] alu_op2,
    output logic [3:0]  alu_sel,
    input  logic [31:0] alu_salida,
    input  logic        alu_zf,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] result,
    output logic        zero,
    output logic        illegal,
    output logic        div0
);

    typedef enum logic [1:0] {IDLE, EXEC, DONE} state_t;

    localparam logic [3:0] SEL_AND = 4'b0000;
    localparam logic [3:0] SEL_OR  = 4'b0001;
    localparam logic [3:0] SEL_ADD = 4'b0010;
    localparam logic [3:0] SEL_MUL = 4'b0011;
    localparam logic [3:0] SEL_DIV = 4'b0100;
    localparam logic [3:0] SEL_NOP = 4'b0101;
    localparam logic [3:0] SEL_SUB = 4'b0110;
    localparam logic [3:0] SEL_SLT = 4'b0111;
    localparam logic [3:0] SEL_BEQ = 4'b1000;
    localparam logic [3:0] SEL_XOR = 4'b1001;

    state_t      state;
    logic [7:0]  counter;
    logic        pend_illegal;
    logic        pend_div0;
    logic [3:0]  dec_sel;
    logic        dec_illegal;
    logic [7:0]  load_cnt;

    always_comb begin
        dec_sel     = SEL_NOP;
        dec_illegal = 1'b0;
        case (aluop)
            2'b00: dec_sel = SEL_ADD;
            2'b01: dec_sel = SEL_BEQ;
            2'b11: dec_sel = SEL_NOP;
            default: begin
                case (funct)
                    6'b100000: dec_sel = SEL_ADD;
                    6'b100010: dec_sel = SEL_SUB;
                    6'b100100: dec_sel = SEL_AND;
                    6'b100101: dec_sel = SEL_OR;
                    6'b101010: dec_sel = SEL_SLT;
                    6'b100110: dec_sel = SEL_XOR;
                    6'b011000: dec_sel = SEL_MUL;
                    6'b011010: dec_sel = SEL_DIV;
                    default:   dec_illegal = 1'b1;
                endcase
            end
        endcase
    end

    // One extra count beyond the op's settle time lets the ALU see freshly registered operands.
    always_comb begin
        load_cnt = 8'd1;
        if (dec_sel == SEL_MUL)
            load_cnt = 8'(MUL_CYCLES);
        else if (dec_sel == SEL_DIV)
            load_cnt = 8'(DIV_CYCLES);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state        <= IDLE;
            in_ready     <= 1'b1;
            alu_op1      <= '0;
            alu_op2      <= '0;
            alu_sel      <= SEL_NOP;
            counter      <= '0;
            pend_illegal <= 1'b0;
            pend_div0    <= 1'b0;
            out_valid    <= 1'b0;
            result       <= '0;
            zero         <= 1'b0;
            illegal      <= 1'b0;
            div0         <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        alu_op1      <= a;
                        alu_op2      <= b;
                        alu_sel      <= dec_sel;
                        counter      <= load_cnt;
                        pend_illegal <= dec_illegal;
                        pend_div0    <= (dec_sel == SEL_DIV) && (b == '0);
                        in_ready     <= 1'b0;
                        state        <= EXEC;
                    end
                end
                EXEC: begin
                    if (counter == '0) begin
                        zero      <= alu_zf;
                        illegal   <= pend_illegal;
                        div0      <= pend_div0;
                        out_valid <= 1'b1;
                        state     <= DONE;
                        // The ALU drives garbage for compare, NOP-on-illegal and divide by zero.
                        if (pend_illegal || alu_sel == SEL_BEQ)
                            result <= '0;
                        else if (pend_div0)
                            result <= 32'hFFFF_FFFF;
                        else
                            result <= alu_salida;
                    end else begin
                        counter <= counter - 8'd1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                        state     <= IDLE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_alu_issue_ctrl.sv
// Bench for alu_issue_ctrl: a behavioural ALU closes the loop, directed vectors plus random ops are
// checked against an arithmetic reference model.
module tb_alu_issue_ctrl;

    localparam int MUL_C = 2;
    localparam int DIV_C = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic        in_ready;
    logic [1:0]  aluop;
    logic [5:0]  funct;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] alu_op1;
    logic [31:0] alu_op2;
    logic [3:0]  alu_sel;
    logic [31:0] alu_salida;
    logic        alu_zf;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] result;
    logic        zero;
    logic        illegal;
    logic        div0;

    int checks = 0;
    int errors = 0;

    typedef struct {
        logic [1:0]  aluop;
        logic [5:0]  funct;
        logic [31:0] a;
        logic [31:0] b;
        logic [3:0]  sel;
        logic [31:0] result;
        logic        zero;
        logic        illegal;
        logic        div0;
        int          lat;
    } vec_t;

    alu_issue_ctrl #(.MUL_CYCLES(MUL_C), .DIV_CYCLES(DIV_C)) dut (
        .clk(clk), .rst_n(rst_n), .in_valid(in_valid), .in_ready(in_ready),
        .aluop(aluop), .funct(funct), .a(a), .b(b),
        .alu_op1(alu_op1), .alu_op2(alu_op2), .alu_sel(alu_sel),
        .alu_salida(alu_salida), .alu_zf(alu_zf),
        .out_valid(out_valid), .out_ready(out_ready),
        .result(result), .zero(zero), .illegal(illegal), .div0(div0)
    );

    always #5 clk = ~clk;

    // Stand-in ALU; undefined outputs are given distinctive junk so overrides are observable.
    always_comb begin
        alu_zf = (alu_op1 == alu_op2);
        case (alu_sel)
            4'b0000: alu_salida = alu_op1 & alu_op2;
            4'b0001: alu_salida = alu_op1 | alu_op2;
            4'b0010: alu_salida = alu_op1 + alu_op2;
            4'b0011: alu_salida = alu_op1 * alu_op2;
            4'b0100: alu_salida = (alu_op2 == 0) ? 32'h0BAD_0BAD : alu_op1 / alu_op2;
            4'b0110: alu_salida = alu_op1 - alu_op2;
            4'b0111: alu_salida = ($signed(alu_op1) < $signed(alu_op2)) ? 32'd1 : 32'd0;
            4'b1000: alu_salida = 32'hDEAD_BEEF;
            4'b1001: alu_salida = alu_op1 ^ alu_op2;
            default: alu_salida = 32'h5A5A_5A5A;
        endcase
    end

    function automatic vec_t refModel(input logic [1:0] op, input logic [5:0] fn,
                                      input logic [31:0] x, input logic [31:0] y);
        vec_t v;
        v.aluop = op; v.funct = fn; v.a = x; v.b = y;
        v.zero = (x == y); v.illegal = 0; v.div0 = 0; v.lat = 2;
        v.sel = 4'b0101; v.result = 32'h5A5A_5A5A;
        if (op == 2'b00) begin v.sel = 4'b0010; v.result = x + y; end
        else if (op == 2'b01) begin v.sel = 4'b1000; v.result = 0; end
        else if (op == 2'b10) begin
            case (fn)
                6'b100000: begin v.sel = 4'b0010; v.result = x + y; end
                6'b100010: begin v.sel = 4'b0110; v.result = x - y; end
                6'b100100: begin v.sel = 4'b0000; v.result = x & y; end
                6'b100101: begin v.sel = 4'b0001; v.result = x | y; end
                6'b101010: begin v.sel = 4'b0111; v.result = ($signed(x) < $signed(y)) ? 1 : 0; end
                6'b100110: begin v.sel = 4'b1001; v.result = x ^ y; end
                6'b011000: begin v.sel = 4'b0011; v.result = x * y; v.lat = 2 + MUL_C - 1; end
                6'b011010: begin
                    v.sel = 4'b0100; v.lat = 2 + DIV_C - 1;
                    v.div0 = (y == 0);
                    v.result = (y == 0) ? 32'hFFFF_FFFF : x / y;
                end
                default: begin v.sel = 4'b0101; v.illegal = 1; v.result = 0; end
            endcase
        end
        return v;
    endfunction

    task automatic checkOutput(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("[TB] FAIL %s: got %h, expected %h", name, act, exp);
        end
    endtask

    task automatic applyStimulus(input vec_t v, input int hold, input bit poke, input string tag);
        int lat;
        @(negedge clk);
        in_valid = 1'b1; aluop = v.aluop; funct = v.funct; a = v.a; b = v.b;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checkOutput({tag, " sel"}, 32'(alu_sel), 32'(v.sel));
        checkOutput({tag, " in_ready busy"}, 32'(in_ready), 32'd0);
        if (poke) begin
            in_valid = 1'b1; aluop = 2'b00; a = ~v.a; b = v.a;
        end
        lat = 0;
        while (!out_valid && lat < 64) begin
            @(posedge clk); #1;
            lat++;
        end
        checkOutput({tag, " latency"}, 32'(lat), 32'(v.lat));
        checkOutput({tag, " op1 held"}, alu_op1, v.a);
        checkOutput({tag, " result"}, result, v.result);
        checkOutput({tag, " zero"}, 32'(zero), 32'(v.zero));
        checkOutput({tag, " illegal"}, 32'(illegal), 32'(v.illegal));
        checkOutput({tag, " div0"}, 32'(div0), 32'(v.div0));
        repeat (hold) begin @(posedge clk); #1; end
        if (hold > 0) begin
            checkOutput({tag, " held valid"}, 32'(out_valid), 32'd1);
            checkOutput({tag, " held result"}, result, v.result);
            checkOutput({tag, " held in_ready"}, 32'(in_ready), 32'd0);
        end
        in_valid = 1'b0;
        out_ready = 1'b1;
        @(posedge clk); #1;
        out_ready = 1'b0;
        checkOutput({tag, " valid drop"}, 32'(out_valid), 32'd0);
        checkOutput({tag, " in_ready back"}, 32'(in_ready), 32'd1);
    endtask

    initial begin
        #2_000_000;
        $display("[TB] FAIL watchdog: simulation did not finish in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        vec_t vecs[14];
        logic [5:0] functs[10];
        vec_t v;

        vecs[0]  = '{2'b10, 6'b100000, 32'd5, 32'd7, 4'b0010, 32'd12, 1'b0, 1'b0, 1'b0, 2};
        vecs[1]  = '{2'b01, 6'b000000, 32'h1234, 32'h1234, 4'b1000, 32'd0, 1'b1, 1'b0, 1'b0, 2};
        vecs[2]  = '{2'b10, 6'b100010, 32'd9, 32'd9, 4'b0110, 32'd0, 1'b1, 1'b0, 1'b0, 2};
        vecs[3]  = '{2'b10, 6'b011010, 32'd100, 32'd7, 4'b0100, 32'd14, 1'b0, 1'b0, 1'b0, 5};
        vecs[4]  = '{2'b10, 6'b011010, 32'd100, 32'd0, 4'b0100, 32'hFFFF_FFFF, 1'b0, 1'b0, 1'b1, 5};
        vecs[5]  = '{2'b10, 6'b100111, 32'hF0, 32'h0F, 4'b0101, 32'd0, 1'b0, 1'b1, 1'b0, 2};
        vecs[6]  = '{2'b10, 6'b100100, 32'hF0, 32'h0F, 4'b0000, 32'd0, 1'b0, 1'b0, 1'b0, 2};
        vecs[7]  = '{2'b10, 6'b011000, 32'd6, 32'd7, 4'b0011, 32'd42, 1'b0, 1'b0, 1'b0, 3};
        vecs[8]  = '{2'b00, 6'b111111, 32'hFFFF_FFFF, 32'd1, 4'b0010, 32'd0, 1'b0, 1'b0, 1'b0, 2};
        vecs[9]  = '{2'b10, 6'b101010, 32'hFFFF_FFFF, 32'd1, 4'b0111, 32'd1, 1'b0, 1'b0, 1'b0, 2};
        vecs[10] = '{2'b11, 6'b100000, 32'd3, 32'd3, 4'b0101, 32'h5A5A_5A5A, 1'b1, 1'b0, 1'b0, 2};
        vecs[11] = '{2'b10, 6'b100101, 32'hF0, 32'h0F, 4'b0001, 32'hFF, 1'b0, 1'b0, 1'b0, 2};
        vecs[12] = '{2'b10, 6'b100110, 32'hFF, 32'h0F, 4'b1001, 32'hF0, 1'b0, 1'b0, 1'b0, 2};
        vecs[13] = '{2'b10, 6'b000000, 32'd1, 32'd2, 4'b0101, 32'd0, 1'b0, 1'b1, 1'b0, 2};

        functs = '{6'b100000, 6'b100010, 6'b100100, 6'b100101, 6'b101010,
                   6'b100110, 6'b011000, 6'b011010, 6'b100111, 6'b000010};

        rst_n = 1'b0; in_valid = 1'b0; out_ready = 1'b0;
        aluop = '0; funct = '0; a = '0; b = '0;
        repeat (3) @(negedge clk);
        checkOutput("reset sel", 32'(alu_sel), 32'h5);
        checkOutput("reset result", result, 32'd0);
        checkOutput("reset op1", alu_op1, 32'd0);
        checkOutput("reset op2", alu_op2, 32'd0);
        checkOutput("reset out_valid", 32'(out_valid), 32'd0);
        checkOutput("reset flags", 32'({zero, illegal, div0}), 32'd0);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("reset in_ready", 32'(in_ready), 32'd1);

        for (int i = 0; i < 14; i++)
            applyStimulus(vecs[i], 0, 1'b0, $sformatf("vec%0d", i));

        v = refModel(2'b10, 6'b100000, 32'd3, 32'd4);
        applyStimulus(v, 10, 1'b0, "hold add");
        v = refModel(2'b10, 6'b011010, 32'd1000, 32'd33);
        applyStimulus(v, 2, 1'b1, "busy poke div");

        // Reset in the middle of a divide, with div0 and result still set from the previous op.
        applyStimulus(vecs[4], 0, 1'b0, "pre-reset div0");
        @(negedge clk);
        in_valid = 1'b1; aluop = 2'b10; funct = 6'b011010; a = 32'd100; b = 32'd7;
        @(posedge clk); #1;
        in_valid = 1'b0;
        @(posedge clk); #3;
        rst_n = 1'b0;
        #1;
        checkOutput("midreset sel", 32'(alu_sel), 32'h5);
        checkOutput("midreset op1", alu_op1, 32'd0);
        checkOutput("midreset result", result, 32'd0);
        checkOutput("midreset div0", 32'(div0), 32'd0);
        checkOutput("midreset out_valid", 32'(out_valid), 32'd0);
        repeat (2) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        checkOutput("postreset in_ready", 32'(in_ready), 32'd1);
        checkOutput("postreset no stale", 32'(out_valid), 32'd0);
        v = refModel(2'b00, 6'b000000, 32'd1, 32'd1);
        applyStimulus(v, 0, 1'b0, "postreset add");

        for (int i = 0; i < 40; i++) begin
            logic [31:0] x, y;
            x = $urandom;
            case ($urandom_range(0, 4))
                0: y = x;
                1: y = 32'd0;
                2: y = $urandom_range(1, 50);
                default: y = $urandom;
            endcase
            if ($urandom_range(0, 1) == 1)
                v = refModel(2'b10, functs[$urandom_range(0, 9)], x, y);
            else
                v = refModel(2'($urandom_range(0, 3)), 6'($urandom_range(0, 63)), x, y);
            applyStimulus(v, $urandom_range(0, 2), 1'($urandom_range(0, 1)), $sformatf("rand%0d", i));
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
